alu_op_decoder: RTL and testbench

- Instruction-decode stage that produces the 5-bit Alu_Op consumed by the 8-bit ALU. It is the upstream producer of the ALU opcode interface.
- Accepts instruction bytes from fetch over a valid/ready handshake and assembles one-byte and two-byte instructions with an FSM.
- Emits one decoded control word per instruction: Alu_Op, destination/source register, immediate, immediate-select and illegal flag.
- The output is held under downstream backpressure. A flush input discards partial instructions on branch redirect.

---
 rtl/alu_op_decoder.sv | 163 ++++++++++++++++
 tb/tb_alu_op_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_decoder.sv
// Instruction-decode stage: assembles one- and two-byte instructions from fetch
// and emits a registered control word (Alu_Op, Rd, Rs, Imm, Use_Imm, Illegal).
module alu_op_decoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] In_Byte,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [4:0]        Alu_Op,
  output logic [2:0]        Rd,
  output logic [2:0]        Rs,
  output logic [DATA_W-1:0] Imm,
  output logic              Use_Imm,
  output logic              Illegal,
  output logic [CNT_W-1:0]  Instr_Count
);

  typedef enum logic [1:0] {S_OP, S_OPR, S_OUT} state_t;

  localparam logic [1:0] C_ONE = 2'd0;
  localparam logic [1:0] C_REG = 2'd1;
  localparam logic [1:0] C_IMM = 2'd2;

  function automatic logic [1:0] op_class(input logic [4:0] op);
    logic [1:0] c;
    case (op)
      5'd2, 5'd3, 5'd4, 5'd5:                   c = C_REG;
      5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
      5'd24, 5'd27, 5'd28, 5'd29, 5'd31:        c = C_IMM;
      default:                                  c = C_ONE;
    endcase
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [4:0]          op_q, op_d;
  logic [2:0]          rd_q, rd_d;
  logic [4:0]          alu_op_q, alu_op_d;
  logic [2:0]          rd_out_q, rd_out_d;
  logic [2:0]          rs_q, rs_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                use_imm_q, use_imm_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept;
  logic                consume;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_OP;
    else     state_q <= state_d;
  end

  // Next-state logic; Flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = S_OP;
    end else begin
      case (state_q)
        S_OP:    if (accept) state_d = (op_class(In_Byte[7:3]) == C_ONE) ? S_OUT : S_OPR;
        S_OPR:   if (accept) state_d = S_OUT;
        S_OUT:   if (Out_Ready) state_d = S_OP;
        default: state_d = S_OP;
      endcase
    end
  end

  // Handshake outputs
  always_comb begin
    In_Ready  = (state_q != S_OUT) && !Flush;
    Out_Valid = (state_q == S_OUT);
  end

  assign accept  = In_Valid && In_Ready;
  assign consume = Out_Valid && Out_Ready && !Flush;

  // Field assembly: byte 0 latches op/rd, final byte loads the output word
  always_comb begin
    op_d      = op_q;
    rd_d      = rd_q;
    alu_op_d  = alu_op_q;
    rd_out_d  = rd_out_q;
    rs_d      = rs_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    illegal_d = illegal_q;
    cnt_d     = consume ? cnt_q + CNT_W'(1) : cnt_q;
    if (accept && state_q == S_OP) begin
      op_d = In_Byte[7:3];
      rd_d = In_Byte[2:0];
      if (op_class(In_Byte[7:3]) == C_ONE) begin
        alu_op_d  = In_Byte[7:3];
        rd_out_d  = In_Byte[2:0];
        rs_d      = 3'd0;
        imm_d     = '0;
        use_imm_d = 1'b0;
        illegal_d = 1'b0;
      end
    end else if (accept && state_q == S_OPR) begin
      rd_out_d = rd_q;
      if (op_class(op_q) == C_REG) begin
        imm_d     = '0;
        use_imm_d = 1'b0;
        // Register byte must carry zeros above the rs field
        if (In_Byte[DATA_W-1:3] != '0) begin
          alu_op_d  = 5'd0;
          rs_d      = 3'd0;
          illegal_d = 1'b1;
        end else begin
          alu_op_d  = op_q;
          rs_d      = In_Byte[2:0];
          illegal_d = 1'b0;
        end
      end else begin
        alu_op_d  = op_q;
        rs_d      = 3'd0;
        imm_d     = In_Byte;
        use_imm_d = 1'b1;
        illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 5'd0;
      rd_q      <= 3'd0;
      alu_op_q  <= 5'd0;
      rd_out_q  <= 3'd0;
      rs_q      <= 3'd0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      op_q      <= op_d;
      rd_q      <= rd_d;
      alu_op_q  <= alu_op_d;
      rd_out_q  <= rd_out_d;
      rs_q      <= rs_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Alu_Op      = alu_op_q;
  assign Rd          = rd_out_q;
  assign Rs          = rs_q;
  assign Imm         = imm_q;
  assign Use_Imm     = use_imm_q;
  assign Illegal     = illegal_q;
  assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: directed instruction bytes, expected
// words queued at issue time and popped by a monitor on each output handshake.
module tb_alu_op_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] In_Byte;
  logic       In_Valid;
  logic       In_Ready;
  logic       Flush;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [4:0] Alu_Op;
  logic [2:0] Rd;
  logic [2:0] Rs;
  logic [7:0] Imm;
  logic       Use_Imm;
  logic       Illegal;
  logic [7:0] Instr_Count;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;
    logic       use_imm;
    logic       illegal;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  alu_op_decoder #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .In_Byte(In_Byte), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .Flush(Flush), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Alu_Op(Alu_Op), .Rd(Rd), .Rs(Rs), .Imm(Imm),
    .Use_Imm(Use_Imm), .Illegal(Illegal), .Instr_Count(Instr_Count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [7:0] imm, input logic ui, input logic il);
    exp_t e;
    e.op = op; e.rd = rd; e.rs = rs; e.imm = imm; e.use_imm = ui; e.illegal = il;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 0;
    In_Byte  = b;
    In_Valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (In_Ready) ok = 1;
      @(posedge clk); #1;
    end
    In_Valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte 0x%0h never accepted", b);
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d words pending, expected 0", sb.size());
    end
  endtask

  // Monitor: every valid handshake that is not voided must match the queue head
  always @(negedge clk) begin
    if (!rst && !Flush && Out_Valid && Out_Ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: op 0x%0h rd %0d, expected none", Alu_Op, Rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("alu_op",  32'(Alu_Op),  32'(e.op));
        chk("rd",      32'(Rd),      32'(e.rd));
        chk("rs",      32'(Rs),      32'(e.rs));
        chk("imm",     32'(Imm),     32'(e.imm));
        chk("use_imm", 32'(Use_Imm), 32'(e.use_imm));
        chk("illegal", 32'(Illegal), 32'(e.illegal));
      end
    end
  end

  initial begin
    rst = 1'b1; In_Byte = 8'h00; In_Valid = 1'b0; Flush = 1'b0; Out_Ready = 1'b1;
    exp_cnt = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle
    @(negedge clk);
    chk("rst_in_ready",  32'(In_Ready),    32'd1);
    chk("rst_out_valid", 32'(Out_Valid),   32'd0);
    chk("rst_alu_op",    32'(Alu_Op),      32'd0);
    chk("rst_count",     32'(Instr_Count), 32'd0);
    @(posedge clk); #1;

    // One-byte instruction, latency one cycle
    push(5'b01110, 3'd3, 3'd0, 8'h00, 1'b0, 1'b0);
    send(8'h73);
    @(negedge clk);
    chk("one_latency_valid", 32'(Out_Valid), 32'd1);
    chk("one_in_ready_low",  32'(In_Ready),  32'd0);
    wait_done(); exp_cnt++;
    chk("one_count", 32'(Instr_Count), 32'(exp_cnt));

    // Register type, legal then illegal
    push(5'b00010, 3'd1, 3'd5, 8'h00, 1'b0, 1'b0);
    send(8'h11); send(8'h05);
    wait_done(); exp_cnt++;
    push(5'b00000, 3'd1, 3'd0, 8'h00, 1'b0, 1'b1);
    send(8'h11); send(8'h45);
    wait_done(); exp_cnt++;
    chk("reg_count", 32'(Instr_Count), 32'(exp_cnt));

    // Immediate type under 3 cycles of backpressure
    Out_Ready = 1'b0;
    push(5'b11011, 3'd0, 3'd0, 8'h7F, 1'b1, 1'b0);
    send(8'hD8); send(8'h7F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid",    32'(Out_Valid),   32'd1);
      chk("hold_alu_op",   32'(Alu_Op),      32'h1B);
      chk("hold_imm",      32'(Imm),         32'h7F);
      chk("hold_use_imm",  32'(Use_Imm),     32'd1);
      chk("hold_in_ready", 32'(In_Ready),    32'd0);
      chk("hold_count",    32'(Instr_Count), 32'(exp_cnt));
    end
    @(posedge clk); #1;
    Out_Ready = 1'b1;
    wait_done(); exp_cnt++;
    chk("imm_count", 32'(Instr_Count), 32'(exp_cnt));

    // Flush discards a partial instruction and rejects the flush-cycle byte
    send(8'h11);
    Flush = 1'b1; In_Valid = 1'b1; In_Byte = 8'h05;
    @(negedge clk);
    chk("flush_in_ready", 32'(In_Ready), 32'd0);
    @(posedge clk); #1;
    Flush = 1'b0; In_Valid = 1'b0;
    push(5'b01110, 3'd3, 3'd0, 8'h00, 1'b0, 1'b0);
    send(8'h73);
    wait_done(); exp_cnt++;
    chk("flush_partial_count", 32'(Instr_Count), 32'(exp_cnt));

    // Flush of a held word, coinciding with Out_Ready
    Out_Ready = 1'b0;
    send(8'h73);
    @(negedge clk);
    chk("flush_held_valid", 32'(Out_Valid), 32'd1);
    @(posedge clk); #1;
    Flush = 1'b1; Out_Ready = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    @(negedge clk);
    chk("flush_held_drop",  32'(Out_Valid),   32'd0);
    chk("flush_held_count", 32'(Instr_Count), 32'(exp_cnt));
    @(posedge clk); #1;

    // Counter wrap
    while (exp_cnt != 8'd255) begin
      push(5'b00000, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
      send(8'h00);
      exp_cnt++;
    end
    wait_done();
    chk("count_255", 32'(Instr_Count), 32'd255);
    push(5'b00000, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
    send(8'h00);
    wait_done(); exp_cnt++;
    chk("count_wrap", 32'(Instr_Count), 32'd0);

    // Reset while waiting for byte 1
    push(5'b01110, 3'd3, 3'd0, 8'h00, 1'b0, 1'b0);
    send(8'h73);
    wait_done();
    send(8'hD8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_valid", 32'(Out_Valid),   32'd0);
    chk("rstmid_alu",   32'(Alu_Op),      32'd0);
    chk("rstmid_rd",    32'(Rd),          32'd0);
    chk("rstmid_count", 32'(Instr_Count), 32'd0);
    exp_cnt = 8'd0;
    push(5'b00010, 3'd1, 3'd5, 8'h00, 1'b0, 1'b0);
    send(8'h11); send(8'h05);
    wait_done(); exp_cnt++;
    chk("post_rst_count", 32'(Instr_Count), 32'(exp_cnt));

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
